// File: rtl/program_sequencer.sv
// Instruction-issue stage for the bit-serial core: loadable program store, PC walk with
// start/pcincr handshake, halt, loop restart and a sticky watchdog on stalled instructions.
module program_sequencer #(
    parameter int ADDR_W  = 4,
    parameter int INSTR_W = 3,
    parameter int TIMEOUT = 31
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load_en,
    input  logic [ADDR_W-1:0]  i_load_addr,
    input  logic [INSTR_W-1:0] i_load_data,
    input  logic               i_run,
    input  logic               i_halt,
    input  logic               i_loop,
    input  logic [ADDR_W-1:0]  i_last_addr,
    input  logic               i_con_pcincr,
    output logic [INSTR_W-1:0] o_data_instruction,
    output logic               o_start,
    output logic [ADDR_W-1:0]  o_pc,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err_timeout
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int TMR_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_ERR
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  last_q, last_d;
    logic               loop_q, loop_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               start_q, start_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               store_we;

    logic [INSTR_W-1:0] store_q [DEPTH];

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        last_d   = last_q;
        loop_d   = loop_q;
        timer_d  = timer_q;
        instr_d  = instr_q;
        start_d  = 1'b0;
        done_d   = 1'b0;
        err_d    = err_q;
        store_we = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A load in the same cycle as run wins; the run request is dropped.
                if (i_load_en) begin
                    store_we = 1'b1;
                end else if (i_run) begin
                    pc_d    = '0;
                    loop_d  = i_loop;
                    last_d  = i_last_addr;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (i_halt) begin
                    state_d = ST_IDLE;
                end else begin
                    instr_d = store_q[pc_q];
                    start_d = 1'b1;
                    timer_d = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i_halt) begin
                    state_d = ST_IDLE;
                end else if (i_con_pcincr) begin
                    if (pc_q == last_q) begin
                        if (loop_q) begin
                            pc_d    = '0;
                            state_d = ST_ISSUE;
                        end else begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        pc_d    = pc_q + 1'b1;
                        state_d = ST_ISSUE;
                    end
                end else if (timer_q == TMR_W'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = ST_ERR;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_ISSUE) || (state_d == ST_WAIT);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            last_q  <= '0;
            loop_q  <= 1'b0;
            timer_q <= '0;
            instr_q <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            last_q  <= last_d;
            loop_q  <= loop_d;
            timer_q <= timer_d;
            instr_q <= instr_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Program store keeps its contents across reset.
    always_ff @(posedge i_clk) begin
        if (store_we && !i_rst) begin
            store_q[i_load_addr] <= i_load_data;
        end
    end

    assign o_data_instruction = instr_q;
    assign o_start            = start_q;
    assign o_pc               = pc_q;
    assign o_busy             = busy_q;
    assign o_done             = done_q;
    assign o_err_timeout      = err_q;

endmodule
